// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between IF and MEM with starvation and ack-timeout bounds
module mem_port_arbiter #(
  parameter int MAX_IWAIT   = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        bus_err,
  output logic        stall_if,
  output logic        stall_mem
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t      state_q, state_d;
  logic        own_d_q, own_d_d;
  logic        m_req_q, m_req_d, m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d, iwait_cnt_q, iwait_cnt_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        i_ready_q, i_ready_d, d_ready_q, d_ready_d, bus_err_q, bus_err_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        i_go, d_go, grant_if, tmo_hit;
  // a requester whose ready is showing this cycle is finishing, not asking again
  assign i_go     = i_req & ~i_ready_q;
  assign d_go     = d_req & ~d_ready_q;
  assign grant_if = i_go & (~d_go | (iwait_cnt_q == 4'(MAX_IWAIT)));
  assign tmo_hit  = tmo_cnt_q == 8'(ACK_TIMEOUT - 1);
  // next-state, grant latching, response capture and timeout handling
  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_be_d      = m_be_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    iwait_cnt_d = iwait_cnt_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    bus_err_d   = 1'b0;
    tmo_cnt_d   = 8'd0;
    case (state_q)
      IDLE: if (i_go | d_go) begin
        state_d     = ISSUE;
        own_d_d     = ~grant_if;
        m_req_d     = 1'b1;
        m_we_d      = ~grant_if & d_we;
        m_be_d      = grant_if ? 4'hF : d_be;
        m_addr_d    = grant_if ? i_addr : d_addr;
        m_wdata_d   = grant_if ? 32'h0 : d_wdata;
        iwait_cnt_d = grant_if ? 4'd0 : iwait_cnt_q + 4'(i_go);
      end
      ISSUE: if (m_ack) begin
        state_d   = RESP;
        m_req_d   = 1'b0;
        i_ready_d = ~own_d_q;
        d_ready_d = own_d_q;
        i_rdata_d = own_d_q ? i_rdata_q : m_rdata;
        d_rdata_d = (own_d_q & ~m_we_q) ? m_rdata : d_rdata_q;
      end else if (tmo_hit) begin
        state_d   = IDLE;
        m_req_d   = 1'b0;
        bus_err_d = 1'b1;
        i_ready_d = ~own_d_q;
        d_ready_d = own_d_q;
        i_rdata_d = own_d_q ? i_rdata_q : 32'h0;
        d_rdata_d = own_d_q ? 32'h0 : d_rdata_q;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared synchronously
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      own_d_q     <= 1'b0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_be_q      <= 4'h0;
      m_addr_q    <= 32'h0;
      m_wdata_q   <= 32'h0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      iwait_cnt_q <= 4'd0;
      tmo_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_be_q      <= m_be_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
      iwait_cnt_q <= iwait_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end
  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_be      = m_be_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign bus_err   = bus_err_q;
  assign stall_if  = i_req & ~i_ready_q;
  assign stall_mem = d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table of single transactions plus directed arbitration, timeout and reset sequences
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_req, m_we, bus_err, stall_if, stall_mem;
  logic [3:0]  m_be;
  int          pass = 0, total = 0;

  mem_port_arbiter #(.MAX_IWAIT(4), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .bus_err(bus_err),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [7:0]  k;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // one transaction from IDLE: request in cycle 0, ack at cycle 1+k, ready at cycle 2+k
  task automatic do_txn(input vec_t v);
    i_req   = ~v.is_d;
    d_req   = v.is_d;
    i_addr  = v.addr;
    d_addr  = v.addr;
    d_we    = v.we;
    d_be    = v.be;
    d_wdata = v.wdata;
    #1;
    chk1("stall_c0", v.is_d ? stall_mem : stall_if, 1'b1);
    tick();
    chk1("m_req_c1", m_req, 1'b1);
    chk("m_addr", m_addr, v.addr);
    chk1("m_we", m_we, v.exp_we);
    chk("m_be", 32'(m_be), 32'(v.exp_be));
    if (v.is_d) chk("m_wdata", m_wdata, v.wdata);
    for (int j = 0; j < int'(v.k); j++) begin
      tick();
      chk1("m_req_hold", m_req, 1'b1);
    end
    m_ack   = 1'b1;
    m_rdata = v.mrd;
    tick();
    m_ack = 1'b0;
    chk1("m_req_drop", m_req, 1'b0);
    chk1("i_ready", i_ready, ~v.is_d);
    chk1("d_ready", d_ready, v.is_d);
    chk("rdata", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    chk1("stall_at_ready", v.is_d ? stall_mem : stall_if, 1'b0);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    chk1("ready_pulse_end", i_ready | d_ready, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 4'h0, 32'h0040_0000, 32'h1111_1111, 32'h0000_0013, 8'd2, 1'b0, 4'hF, 32'h0000_0013};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h1001_0004, 32'h0000_0000, 32'hCAFE_F00D, 8'd0, 1'b0, 4'hF, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 1'b1, 4'h2, 32'h1001_0001, 32'h0000_AB00, 32'h1234_5678, 8'd1, 1'b1, 4'h2, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b1, 4'h0, 32'h1001_0008, 32'h5555_5555, 32'h9999_AAAA, 8'd0, 1'b1, 4'h0, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 4'hF, 32'h0040_0004, 32'h0000_0000, 32'h0010_0093, 8'd3, 1'b0, 4'hF, 32'h0010_0093};
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_ready", i_ready | d_ready, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    for (int n = 0; n < 5; n++) do_txn(vecs[n]);
    // simultaneous requests: MEM store first, then IF
    i_req = 1'b1; i_addr = 32'h0040_0008;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("both_m_addr", m_addr, 32'h1001_0000);
    chk1("both_m_we", m_we, 1'b1);
    chk("both_m_wdata", m_wdata, 32'hDEAD_BEEF);
    m_ack = 1'b1; m_rdata = 32'h0000_0077;
    tick();
    m_ack = 1'b0;
    chk1("both_d_ready", d_ready, 1'b1);
    chk1("both_i_ready", i_ready, 1'b0);
    chk1("both_stall_if", stall_if, 1'b1);
    d_req = 1'b0;
    tick();
    chk1("both_idle_m_req", m_req, 1'b0);
    chk1("both_idle_stall_if", stall_if, 1'b1);
    tick();
    chk1("both_if_m_req", m_req, 1'b1);
    chk("both_if_m_addr", m_addr, 32'h0040_0008);
    chk1("both_if_m_we", m_we, 1'b0);
    m_ack = 1'b1; m_rdata = 32'h00C0_0093;
    tick();
    m_ack = 1'b0;
    chk1("both_if_ready", i_ready, 1'b1);
    chk("both_if_rdata", i_rdata, 32'h00C0_0093);
    chk("both_store_keeps_d_rdata", d_rdata, 32'hCAFE_F00D);
    i_req = 1'b0;
    tick();
    // starvation bound: four MEM wins then IF, twice over
    i_req = 1'b1; i_addr = 32'h0040_000C;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h1002_0000;
    for (int n = 0; n < 10; n++) begin
      d_wdata = 32'(n);
      tick();
      chk("starve_m_addr", m_addr, (n == 4 || n == 9) ? 32'h0040_000C : 32'h1002_0000);
      m_ack = 1'b1; m_rdata = 32'(n);
      tick();
      m_ack = 1'b0;
      chk1("starve_i_ready", i_ready, n == 4 || n == 9);
      chk1("starve_d_ready", d_ready, !(n == 4 || n == 9));
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    // ack timeout on a load
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1001_0010;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk1("tmo_m_req_high", m_req, 1'b1);
      chk1("tmo_no_err_yet", bus_err, 1'b0);
    end
    tick();
    chk1("tmo_m_req_drop", m_req, 1'b0);
    chk1("tmo_bus_err", bus_err, 1'b1);
    chk1("tmo_d_ready", d_ready, 1'b1);
    chk("tmo_d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    tick();
    chk1("tmo_err_pulse_end", bus_err, 1'b0);
    chk1("tmo_no_reissue", m_req, 1'b0);
    do_txn(vecs[1]);
    // reset during ISSUE followed by a stale ack
    i_req = 1'b1; i_addr = 32'h0040_0010;
    tick();
    chk1("rst_mid_m_req", m_req, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk1("rst_mid_drop", m_req, 1'b0);
    chk("rst_mid_i_rdata", i_rdata, 32'h0);
    rst = 1'b0; i_req = 1'b0;
    m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
    tick();
    m_ack = 1'b0;
    chk1("late_ack_no_ready", i_ready | d_ready, 1'b0);
    chk1("late_ack_no_err", bus_err, 1'b0);
    chk1("late_ack_no_req", m_req, 1'b0);
    chk("late_ack_i_rdata", i_rdata, 32'h0);
    do_txn(vecs[4]);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
